// File: rtl/execute_stage_fwd.sv
// Execute stage with operand forwarding, branch resolution and the E/M pipeline register.
// Define EX_MULDIV_EN to include the iterative multiply/divide unit.
module execute_stage_fwd #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  reg_write_e,
    input  logic                  mem_write_e,
    input  logic [1:0]            result_src_e,
    input  logic                  branch_e,
    input  logic                  jump_e,
    input  logic                  alu_src_e,
    input  logic [3:0]            alu_ctrl_e,
    input  logic [2:0]            funct3_e,
    input  logic                  muldiv_e,
    input  logic [1:0]            md_op_e,
    input  logic [1:0]            fwd_a_e,
    input  logic [1:0]            fwd_b_e,
    input  logic [XLEN-1:0]       rd1_e,
    input  logic [XLEN-1:0]       rd2_e,
    input  logic [XLEN-1:0]       imm_ext_e,
    input  logic [XLEN-1:0]       pc_e,
    input  logic [XLEN-1:0]       pc_plus4_e,
    input  logic [XLEN-1:0]       result_w,
    input  logic [REG_ADDR_W-1:0] rd_e,
    output logic                  pc_src_e,
    output logic [XLEN-1:0]       pc_target_e,
    output logic                  ex_busy,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_m,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic [XLEN-1:0]       alu_result_m,
    output logic [XLEN-1:0]       write_data_m,
    output logic [XLEN-1:0]       pc_plus4_m
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] srcA, fwdB, srcB, aluOut;
    logic            cond, exBusy, mdDone;
    logic [XLEN-1:0] mdResult;

    always_comb begin
        case (fwd_a_e)
            2'b01:   srcA = result_w;
            2'b10:   srcA = alu_result_m;
            default: srcA = rd1_e;
        endcase
        case (fwd_b_e)
            2'b01:   fwdB = result_w;
            2'b10:   fwdB = alu_result_m;
            default: fwdB = rd2_e;
        endcase
    end

    assign srcB = alu_src_e ? imm_ext_e : fwdB;

    always_comb begin
        aluOut = '0;
        case (alu_ctrl_e)
            4'd0: aluOut = srcA + srcB;
            4'd1: aluOut = srcA - srcB;
            4'd2: aluOut = srcA & srcB;
            4'd3: aluOut = srcA | srcB;
            4'd4: aluOut = srcA ^ srcB;
            4'd5: aluOut = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            4'd6: aluOut = {{(XLEN-1){1'b0}}, srcA < srcB};
            4'd7: aluOut = srcA << srcB[SHW-1:0];
            4'd8: aluOut = srcA >> srcB[SHW-1:0];
            4'd9: aluOut = $signed(srcA) >>> srcB[SHW-1:0];
            default: aluOut = '0;
        endcase
    end

    // Branches always compare the register operands, even when the ALU takes the immediate.
    always_comb begin
        cond = 1'b0;
        case (funct3_e)
            3'd0: cond = (srcA == fwdB);
            3'd1: cond = (srcA != fwdB);
            3'd4: cond = ($signed(srcA) <  $signed(fwdB));
            3'd5: cond = ($signed(srcA) >= $signed(fwdB));
            3'd6: cond = (srcA <  fwdB);
            3'd7: cond = (srcA >= fwdB);
            default: cond = 1'b0;
        endcase
    end

    assign pc_target_e = pc_e + imm_ext_e;
    assign pc_src_e    = ((branch_e & cond) | jump_e) & ~exBusy;
    assign ex_busy     = exBusy;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} mdState_t;

    mdState_t        state, stateNext;
    logic [SHW-1:0]  cnt;
    logic [1:0]      mdOp;
    logic [XLEN-1:0] accHi, accLo, mdOpnd;
    logic [XLEN:0]   mulSum, remSh;
    logic [XLEN-1:0] divDiff;
    logic            divGe, mdStart;

    assign mdStart = muldiv_e & ~stall_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (mdStart) stateNext = RUN;
            RUN:     if (flush_i) stateNext = IDLE;
                     else if (cnt == '0) stateNext = DONE;
            DONE:    if (flush_i | ~stall_i) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // accHi:accLo holds the running product, or remainder:quotient while dividing.
    assign mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, mdOpnd} : {(XLEN+1){1'b0}});
    assign remSh   = {accHi, accLo[XLEN-1]};
    assign divGe   = (remSh >= {1'b0, mdOpnd});
    assign divDiff = remSh[XLEN-1:0] - mdOpnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mdOp   <= '0;
            accHi  <= '0;
            accLo  <= '0;
            mdOpnd <= '0;
        end else if (state == IDLE) begin
            if (mdStart) begin
                cnt    <= SHW'(XLEN-1);
                mdOp   <= md_op_e;
                accHi  <= '0;
                accLo  <= md_op_e[1] ? srcA : fwdB;
                mdOpnd <= md_op_e[1] ? fwdB : srcA;
            end
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            if (!mdOp[1]) begin
                {accHi, accLo} <= {mulSum, accLo[XLEN-1:1]};
            end else begin
                accHi <= divGe ? divDiff : remSh[XLEN-1:0];
                accLo <= {accLo[XLEN-2:0], divGe};
            end
        end
    end

    assign exBusy   = ((state == IDLE) & muldiv_e & ~flush_i) | (state == RUN);
    assign mdDone   = (state == DONE);
    assign mdResult = mdOp[0] ? accHi : accLo;
`else
    logic unusedMd;
    assign unusedMd = ^{muldiv_e, md_op_e};
    assign exBusy   = 1'b0;
    assign mdDone   = 1'b0;
    assign mdResult = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst || (!stall_i && (flush_i || exBusy))) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (!stall_i) begin
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            alu_result_m <= mdDone ? mdResult : aluOut;
            write_data_m <= fwdB;
            pc_plus4_m   <= pc_plus4_e;
        end
    end
endmodule
